// File: rtl/fd_integrator.sv
// Streaming first-order integrator y[n] = y[n-1] + x[n] with optional power-of-two leak,
// saturating accumulator/output, single-register valid/ready output stage and sticky saturation flag.
module fd_integrator #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int LEAK_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out,
  input  logic                     clear,
  output logic                     sat_flag,
  input  logic                     sat_clr
);

  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > ACC_MAX)      r = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) r = ACC_MIN[ACC_W-1:0];
    else                  r = v[ACC_W-1:0];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > OUT_MAX)      r = OUT_MAX[DATA_W-1:0];
    else if (v < OUT_MIN) r = OUT_MIN[DATA_W-1:0];
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [DATA_W-1:0] out_p0;
  logic                     vld_p0;
  logic                     sat_p0;

  logic                     accept;
  logic                     consume;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] out_nxt;
  logic                     sat_ev;

  // Output register can be refilled in the same cycle it drains, so ready follows out_ready.
  assign in_ready  = !clear && (!vld_p0 || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = vld_p0 && out_ready;
  assign out       = out_p0;
  assign out_valid = vld_p0;
  assign sat_flag  = sat_p0;

  always_comb begin
    acc_shr = '0;
    if (LEAK_SHIFT != 0) acc_shr = acc_p0 >>> LEAK_SHIFT;
    // Leak never exceeds |acc|, so acc - leak + in always fits in ACC_W+1 bits.
    sum     = {acc_p0[ACC_W-1], acc_p0}
            + {{(SUM_W-DATA_W){in[DATA_W-1]}}, in}
            - {acc_shr[ACC_W-1], acc_shr};
    acc_nxt = sat_acc(sum);
    out_nxt = sat_out(acc_nxt);
    sat_ev  = accept &&
              ((sum != {acc_nxt[ACC_W-1], acc_nxt}) ||
               (acc_nxt != {{(ACC_W-DATA_W){out_nxt[DATA_W-1]}}, out_nxt}));
  end

  // Stage p0: accumulator, output register and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      out_p0 <= '0;
      vld_p0 <= 1'b0;
      sat_p0 <= 1'b0;
    end else begin
      if (clear) begin
        acc_p0 <= '0;
        vld_p0 <= 1'b0;
      end else if (accept) begin
        acc_p0 <= acc_nxt;
        out_p0 <= out_nxt;
        vld_p0 <= 1'b1;
      end else if (consume) begin
        vld_p0 <= 1'b0;
      end

      if (sat_ev)       sat_p0 <= 1'b1;
      else if (sat_clr) sat_p0 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fd_integrator.sv
// Bench for fd_integrator: two instances (no leak, leak 2^-2) share stimulus and are
// compared each cycle against a plain-integer reference model, plus directed value checks.
module tb_fd_integrator;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clear = 1'b0;
  logic sat_clr = 1'b0;
  logic signed [DATA_W-1:0] din = '0;

  logic [1:0] rdy;
  logic [1:0] vld;
  logic [1:0] sat;
  logic signed [DATA_W-1:0] dout [2];

  int n_checks = 0;
  int n_errors = 0;

  longint m_acc [2];
  longint m_out [2];
  bit     m_vld [2];
  bit     m_sat [2];

  always #5 clk = ~clk;

  fd_integrator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEAK_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in(din),
    .out_valid(vld[0]), .out_ready(out_ready), .out(dout[0]), .clear(clear),
    .sat_flag(sat[0]), .sat_clr(sat_clr)
  );

  fd_integrator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEAK_SHIFT(2)) dut_lk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in(din),
    .out_valid(vld[1]), .out_ready(out_ready), .out(dout[1]), .clear(clear),
    .sat_flag(sat[1]), .sat_clr(sat_clr)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic bit model_ready(input int i);
    return !clear && (!m_vld[i] || out_ready);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_out[i] = 0; m_vld[i] = 0; m_sat[i] = 0;
    end
  endfunction

  // One rising edge of the reference: y = clamp(acc + x - floor(acc / 2^L)).
  function automatic void model_edge(input int i);
    longint amax, amin, omax, omin, d, leak, s, a, o;
    bit     take, ev;
    int     sh;
    sh   = (i == 0) ? 0 : 2;
    amax = (longint'(1) <<< (ACC_W-1)) - 1;  amin = -(longint'(1) <<< (ACC_W-1));
    omax = (longint'(1) <<< (DATA_W-1)) - 1; omin = -(longint'(1) <<< (DATA_W-1));
    take = in_valid && model_ready(i);
    ev   = 0;
    if (clear) begin
      m_acc[i] = 0; m_vld[i] = 0;
    end else if (take) begin
      leak = 0;
      if (sh > 0) begin
        d    = longint'(1) <<< sh;
        leak = m_acc[i] / d;
        if ((m_acc[i] % d != 0) && (m_acc[i] < 0)) leak = leak - 1;
      end
      s  = m_acc[i] + longint'(din) - leak;
      a  = clampl(s, amin, amax);
      o  = clampl(a, omin, omax);
      ev = (a != s) || (o != a);
      m_acc[i] = a; m_out[i] = o; m_vld[i] = 1;
    end else if (m_vld[i] && out_ready) begin
      m_vld[i] = 0;
    end
    if (ev) m_sat[i] = 1;
    else if (sat_clr) m_sat[i] = 0;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("out%0d", i), longint'(dout[i]), m_out[i]);
      check_eq($sformatf("out_valid%0d", i), longint'(vld[i]), longint'(m_vld[i]));
      check_eq($sformatf("sat_flag%0d", i), longint'(sat[i]), longint'(m_sat[i]));
    end
  endtask

  // Called at edge+1; checks comb ready, advances one clock, checks registered outputs.
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("in_ready%0d", i), longint'(rdy[i]), longint'(model_ready(i)));
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input int x);
    in_valid = v;
    din      = DATA_W'(x);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; clear = 1'b0; sat_clr = 1'b0; out_ready = 1'b1; din = '0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rt_x [5];
    int rt_d [5];
    int prev;
    model_reset();
    do_reset();

    // Impulse
    drive(1, 100);
    check_eq("impulse0", longint'(dout[0]), 100);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0);
      check_eq("impulse", longint'(dout[0]), 100);
    end

    // Round trip through a first-difference filter
    do_reset();
    rt_x = '{0, 10, 30, 25, -5};
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      rt_d[k] = rt_x[k] - prev;
      prev    = rt_x[k];
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, rt_d[k]);
      check_eq("roundtrip", longint'(dout[0]), longint'(rt_x[k]));
    end
    check_eq("roundtrip_sat", longint'(sat[0]), 0);

    // Saturation
    do_reset();
    drive(1, 20000);
    check_eq("sat_a", longint'(dout[0]), 20000);
    drive(1, 20000);
    check_eq("sat_b", longint'(dout[0]), 32767);
    check_eq("sat_flag_set", longint'(sat[0]), 1);
    drive(1, -20000);
    check_eq("sat_back", longint'(dout[0]), 20000);
    sat_clr = 1'b1;
    drive(0, 0);
    sat_clr = 1'b0;
    check_eq("sat_clr", longint'(sat[0]), 0);

    // Leak
    do_reset();
    drive(1, 64);
    check_eq("leak0", longint'(dout[1]), 64);
    drive(1, 0);
    check_eq("leak1", longint'(dout[1]), 48);
    drive(1, 0);
    check_eq("leak2", longint'(dout[1]), 36);
    drive(1, 0);
    check_eq("leak3", longint'(dout[1]), 27);

    // Back-pressure
    do_reset();
    drive(1, 5);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 7);
      check_eq("bp_ready", longint'(rdy[0]), 0);
      check_eq("bp_hold", longint'(dout[0]), 5);
    end
    out_ready = 1'b1;
    drive(1, 7);
    check_eq("bp_release", longint'(dout[0]), 12);

    // Clear, then asynchronous reset mid-stream
    do_reset();
    drive(1, 500);
    check_eq("clr_acc", longint'(dout[0]), 500);
    clear = 1'b1;
    drive(1, 9);
    clear = 1'b0;
    check_eq("clr_vld", longint'(vld[0]), 0);
    check_eq("clr_out_hold", longint'(dout[0]), 500);
    drive(1, 3);
    check_eq("clr_next", longint'(dout[0]), 3);
    drive(1, 32767);
    drive(1, 32767);
    check_eq("pre_rst_sat", longint'(sat[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out", longint'(dout[0]), 0);
    check_eq("arst_vld", longint'(vld[0]), 0);
    check_eq("arst_sat", longint'(sat[0]), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      sat_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768);
      else                           drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 400)) - 200);
    end

    // Long one-sided burst to drive the accumulator into its own clamp
    clear = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      sat_clr = ($urandom_range(0, 63) == 0);
      drive(1, 32767);
    end
    for (int k = 0; k < 600; k++) begin
      sat_clr = ($urandom_range(0, 63) == 0);
      drive(1, -32768);
    end
    sat_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fd_integrator.md
# fd_integrator

Streaming first-order integrator, y[n] = y[n-1] + x[n] with optional leak. It is the reconstruction counterpart of the first-difference high-pass stage. It sits downstream of the differencing filter, or at the far end of a difference-coded link, and rebuilds the original sample stream. It provides valid/ready flow control, saturating arithmetic and a sticky saturation flag.

## Interface
- DATA_W, 16: sample width, signed, for input and output.
- ACC_W, 24: accumulator width, signed. Must be at least DATA_W+2.
- LEAK_SHIFT, 0: leak factor 2^-LEAK_SHIFT per accepted sample. 0 disables leak.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in  input  DATA_W  signed difference sample.
- out_valid  output  1  out holds an integrated sample.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  DATA_W  signed integrated sample, registered.
- clear  input  1  synchronous clear of accumulator and output stage.
- sat_flag  output  1  sticky; set when any saturation occurs.
- sat_clr  input  1  synchronous clear of sat_flag.

## Operation
- Reset (rst_n low, asynchronous): acc=0, out=0, out_valid=0, sat_flag=0. After rst_n releases, in_ready=1.
- Handshake:
  - Input is accepted when in_valid && in_ready && !clear.
  - Output is consumed when out_valid && out_ready.
  - in_ready = !clear && (!out_valid || out_ready). This is a single output register, so full throughput is possible with no bubble.
- Per accepted sample:
  - leak = (LEAK_SHIFT==0) ? 0 : acc >>> LEAK_SHIFT. This is an arithmetic shift, rounding toward -inf.
  - sum = acc + sext(in) - leak, computed at ACC_W+1 bits.
  - acc <= clamp(sum) to the ACC_W signed range.
  - out <= clamp(acc_new) to the DATA_W signed range, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_valid <= 1.
- Saturation: if either clamp is active on an accepted sample, sat_flag <= 1. Otherwise sat_flag holds.
- sat_clr: sat_flag <= 0, unless a saturation event occurs in the same cycle. Set wins over clear.
- Output side: if the output is consumed and no new input is accepted, out_valid <= 0 and out holds its last value. While out_valid=1 && out_ready=0, out and out_valid stay stable.
- clear: acc <= 0 and out_valid <= 0. Any in_valid sample in that cycle is not accepted (in_ready=0). out retains its last value. clear does not affect sat_flag.
- No state machine beyond the output-stage full/empty bit. Two states:
  - EMPTY (out_valid=0) goes to FULL on accept.
  - FULL goes to EMPTY on consume without accept.
  - FULL stays FULL on consume with accept, or with no consume.
  - clear forces EMPTY from either state.

## Timing
- Latency: a sample accepted at edge k appears on out with out_valid=1 right after edge k. It is observable in cycle k+1.
- Throughput: 1 sample/cycle while out_ready=1.
- Back-pressure: in_ready falls in the same cycle out_ready is low and out_valid=1 (combinational path out_ready -> in_ready).
- acc, out, out_valid and sat_flag all change only on rising clk, except on asynchronous reset assertion.
- Reset asserted mid-stream: all state clears immediately. The in-flight output is discarded and no partial sample is emitted.

## Test plan
- Impulse: LEAK_SHIFT=0, out_ready=1, in = 100 then 0,0,0 -> out = 100,100,100,100; out_valid=1 each cycle from cycle 1; sat_flag=0.
- Round trip: drive x = 0,10,30,25,-5 through the first-difference filter, then into fd_integrator (LEAK_SHIFT=0) -> out reproduces x with the filter's delay; no saturation.
- Saturation: DATA_W=16, ACC_W=24, in = 20000 for 2 samples -> out = 20000, then 32767; sat_flag=1.
  - Then in = -20000 -> acc = 20000, out = 20000.
  - sat_clr with no event -> sat_flag=0.
- Leak: LEAK_SHIFT=2, in = 64 then 0,0,0 -> out = 64,48,36,27.
- Back-pressure: out_ready=0 with out_valid=1 -> in_ready=0; out stable for 5 cycles while in_valid=1 with in=7 held. Release out_ready -> 7 accepted next edge, out = prev+7.
- Clear and reset: accumulate to 500, assert clear with in_valid=1, in=9 -> sample dropped, out_valid=0.
  - Next in=3 -> out=3.
  - Pulse rst_n low mid-stream -> out=0, out_valid=0, sat_flag=0 immediately, without waiting for a clock edge.
